// File: rtl/nexys_starship_defense.sv
// Player-side responder: aims at one of four stations, fires with a kill_req/kill_ack
// handshake, runs timed repairs. Optional timed reload: NEXYS_STARSHIP_AUTO_RELOAD_EN.
module nexys_starship_defense #(
  parameter int COOLDOWN_CYCLES = 25_000_000,
  parameter int REPAIR_CYCLES   = 100_000_000,
  parameter int AMMO_MAX        = 8,
  parameter int ACK_TIMEOUT     = 16,
  parameter int RELOAD_CYCLES   = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic       btn_fire,
  input  logic       btn_repair,
  input  logic [1:0] dir_sel,
  input  logic [3:0] monster_present,
  input  logic [3:0] broken,
  input  logic [3:0] kill_ack,
  output logic [3:0] kill_req,
  output logic [3:0] repair_done,
  output logic [3:0] ammo,
  output logic [7:0] hits,
  output logic [7:0] misses,
  output logic       q_Idle,
  output logic       q_Ready,
  output logic       q_Fire,
  output logic       q_Cool,
  output logic       q_Repair,
  output logic       q_Done
);
  // state  | meaning
  // IDLE   | waiting for play_flag
  // READY  | accepting fire / repair commands
  // FIRE   | kill_req raised, waiting for kill_ack or timeout
  // COOL   | post-shot lockout
  // REPAIR | timing a repair of the target station
  // DONE   | game over, frozen until Reset
  localparam logic [5:0] S_IDLE   = 6'b000001;
  localparam logic [5:0] S_READY  = 6'b000010;
  localparam logic [5:0] S_FIRE   = 6'b000100;
  localparam logic [5:0] S_COOL   = 6'b001000;
  localparam logic [5:0] S_REPAIR = 6'b010000;
  localparam logic [5:0] S_DONE   = 6'b100000;

  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int RW = (REPAIR_CYCLES > 1) ? $clog2(REPAIR_CYCLES) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] COOL_LAST = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPAIR_CYCLES - 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]    AMMO_FULL = 4'(AMMO_MAX);

  logic [5:0]    state;
  logic [CW-1:0] cool_cnt;
  logic [RW-1:0] rep_cnt;
  logic [AW-1:0] ack_cnt;
  logic [1:0]    target;
  logic          active;
  logic          ready_stay;

  assign active = |(state & (S_READY | S_FIRE | S_COOL | S_REPAIR));
  // READY is kept unless a fire with ammo or a valid repair is accepted
  assign ready_stay = btn_fire ? (ammo == 4'd0) : !(btn_repair && broken[dir_sel]);
  assign {q_Done, q_Repair, q_Cool, q_Fire, q_Ready, q_Idle} = state;

`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
  localparam int LW = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
  localparam logic [LW-1:0] RELOAD_LAST = LW'(RELOAD_CYCLES - 1);
  logic [LW-1:0] reload_cnt;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      kill_req    <= '0;
      repair_done <= '0;
      ammo        <= AMMO_FULL;
      hits        <= '0;
      misses      <= '0;
      cool_cnt    <= '0;
      rep_cnt     <= '0;
      ack_cnt     <= '0;
      target      <= '0;
`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
      reload_cnt  <= '0;
`endif
    end else begin
      repair_done <= '0;
`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
      reload_cnt  <= '0;
`endif
      if (active && game_over) begin
        state    <= S_DONE;
        kill_req <= '0;
      end else if (active && !play_flag) begin
        state    <= S_IDLE;
        kill_req <= '0;
        ammo     <= AMMO_FULL;
        cool_cnt <= '0;
        rep_cnt  <= '0;
        ack_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: if (play_flag) state <= S_READY;
          S_READY: begin
            if (btn_fire) begin
              if (ammo != 4'd0) begin
                ammo   <= ammo - 4'd1;
                target <= dir_sel;
                if (monster_present[dir_sel]) begin
                  kill_req <= 4'b0001 << dir_sel;
                  ack_cnt  <= '0;
                  state    <= S_FIRE;
                end else begin
                  misses   <= misses + {7'd0, misses != 8'hFF};
                  cool_cnt <= '0;
                  state    <= S_COOL;
                end
              end
            end else if (btn_repair && broken[dir_sel]) begin
              target  <= dir_sel;
              rep_cnt <= '0;
              state   <= S_REPAIR;
            end
`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
            if (ready_stay && ammo < AMMO_FULL) begin
              if (reload_cnt == RELOAD_LAST) ammo <= ammo + 4'd1;
              else reload_cnt <= reload_cnt + LW'(1);
            end
`endif
          end
          S_FIRE: begin
            if (kill_ack[target]) begin
              kill_req <= '0;
              hits     <= hits + {7'd0, hits != 8'hFF};
              cool_cnt <= '0;
              state    <= S_COOL;
            end else if (ack_cnt == ACK_LAST) begin
              kill_req <= '0;
              misses   <= misses + {7'd0, misses != 8'hFF};
              cool_cnt <= '0;
              state    <= S_COOL;
            end else begin
              ack_cnt <= ack_cnt + AW'(1);
            end
          end
          S_COOL: begin
            if (cool_cnt == COOL_LAST) state <= S_READY;
            else cool_cnt <= cool_cnt + CW'(1);
          end
          S_REPAIR: begin
            if (!broken[target]) begin
              state <= S_READY;
            end else if (rep_cnt == REP_LAST) begin
              repair_done <= 4'b0001 << target;
              ammo        <= AMMO_FULL;
              state       <= S_READY;
            end else begin
              rep_cnt <= rep_cnt + RW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nexys_starship_defense.sv
// Bench for nexys_starship_defense: shot table, directed corner sequences and random
// stimulus, all checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_nexys_starship_defense;
  localparam int COOL_N = 4, REP_N = 8, AMMO_N = 3, ACK_N = 5, RELOAD_N = 10;
  localparam int M_IDLE = 0, M_READY = 1, M_FIRE = 2, M_COOL = 3, M_REPAIR = 4, M_DONE = 5;

  logic       Clk = 1'b0, Reset = 1'b1, play_flag = 1'b0, game_over = 1'b0;
  logic       btn_fire = 1'b0, btn_repair = 1'b0;
  logic [1:0] dir_sel = 2'd0;
  logic [3:0] monster_present = 4'd0, broken = 4'd0, kill_ack = 4'd0;
  logic [3:0] kill_req, repair_done, ammo;
  logic [7:0] hits, misses;
  logic       q_Idle, q_Ready, q_Fire, q_Cool, q_Repair, q_Done;

  always #5 Clk = ~Clk;

  nexys_starship_defense #(
    .COOLDOWN_CYCLES(COOL_N), .REPAIR_CYCLES(REP_N), .AMMO_MAX(AMMO_N),
    .ACK_TIMEOUT(ACK_N), .RELOAD_CYCLES(RELOAD_N)
  ) dut (
    .Clk(Clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .btn_fire(btn_fire), .btn_repair(btn_repair), .dir_sel(dir_sel),
    .monster_present(monster_present), .broken(broken), .kill_ack(kill_ack),
    .kill_req(kill_req), .repair_done(repair_done), .ammo(ammo), .hits(hits),
    .misses(misses), .q_Idle(q_Idle), .q_Ready(q_Ready), .q_Fire(q_Fire),
    .q_Cool(q_Cool), .q_Repair(q_Repair), .q_Done(q_Done)
  );

  int n_checks = 0, n_fail = 0;

  // Reference model: mode plus the cycle stamp at which the mode was entered.
  int m_mode, m_cyc, m_entry, m_anchor, m_tgt, m_ammo, m_hits, m_miss;
  logic [3:0] m_req, m_done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cyc = 0; m_entry = 0; m_anchor = 0; m_tgt = 0;
    m_ammo = AMMO_N; m_hits = 0; m_miss = 0; m_req = 4'd0; m_done = 4'd0;
  endtask

  task automatic go(input int mode);
    m_mode = mode; m_entry = m_cyc; m_anchor = m_cyc;
  endtask

  task automatic model_step();
    int age;
    if (Reset) begin model_reset(); return; end
    m_cyc++;
    age = m_cyc - m_entry;
    m_done = 4'd0;
    if (m_mode >= M_READY && m_mode <= M_REPAIR && game_over) begin
      m_req = 4'd0; go(M_DONE);
    end else if (m_mode >= M_READY && m_mode <= M_REPAIR && !play_flag) begin
      m_req = 4'd0; m_ammo = AMMO_N; go(M_IDLE);
    end else begin
      case (m_mode)
        M_IDLE: if (play_flag) go(M_READY);
        M_READY: begin
          if (btn_fire) begin
            if (m_ammo > 0) begin
              m_ammo--; m_tgt = dir_sel;
              if (monster_present[dir_sel]) begin m_req = 4'd0; m_req[dir_sel] = 1'b1; go(M_FIRE); end
              else begin m_miss = (m_miss < 255) ? m_miss + 1 : 255; go(M_COOL); end
            end
          end else if (btn_repair && broken[dir_sel]) begin
            m_tgt = dir_sel; go(M_REPAIR);
          end
`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
          if (m_mode == M_READY && m_ammo < AMMO_N && m_cyc - m_anchor == RELOAD_N) begin
            m_ammo++; m_anchor = m_cyc;
          end
`endif
        end
        M_FIRE: begin
          if (kill_ack[m_tgt]) begin
            m_req = 4'd0; m_hits = (m_hits < 255) ? m_hits + 1 : 255; go(M_COOL);
          end else if (age == ACK_N) begin
            m_req = 4'd0; m_miss = (m_miss < 255) ? m_miss + 1 : 255; go(M_COOL);
          end
        end
        M_COOL: if (age == COOL_N) go(M_READY);
        M_REPAIR: begin
          if (!broken[m_tgt]) go(M_READY);
          else if (age == REP_N) begin
            m_done = 4'd0; m_done[m_tgt] = 1'b1; m_ammo = AMMO_N; go(M_READY);
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [33:0] dut_vec();
    return {q_Done, q_Repair, q_Cool, q_Fire, q_Ready, q_Idle, kill_req, repair_done, ammo, hits, misses};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {6'(1 << m_mode), m_req, m_done, 4'(m_ammo), 8'(m_hits), 8'(m_miss)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check("model", 64'(dut_vec()), 64'(exp_vec()));
  endtask

  task automatic do_reset();
    Reset = 1'b1; game_over = 1'b0; btn_fire = 1'b0; btn_repair = 1'b0; kill_ack = 4'd0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic refill();
    play_flag = 1'b0; tick();
    play_flag = 1'b1; tick();
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!q_Ready && c < 50) begin tick(); c++; end
    check("wait_ready", 64'(q_Ready), 64'd1);
  endtask

  typedef struct {
    logic [1:0] dir;
    logic       mon;
    int         ack_dly;   // negedges of kill_req seen before ack is driven; -1 = never
    logic       wrong;     // ack only the non-target bits
    int         exp_req;
    int         exp_hit;
  } shot_t;
  shot_t shots[6];

  task automatic run_shot(input shot_t s, input int idx);
    int n_req, n_cool, k, h0, m0;
    refill();
    h0 = m_hits; m0 = m_miss;
    dir_sel = s.dir;
    monster_present = s.mon ? (4'b0001 << s.dir) : 4'b0000;
    btn_fire = 1'b1; tick(); btn_fire = 1'b0;
    n_req = 0; n_cool = 0; k = 0;
    for (int c = 0; c < 40 && !q_Ready; c++) begin
      if (kill_req == (4'b0001 << s.dir)) begin
        n_req++;
        if (s.wrong) kill_ack = 4'b1111 ^ (4'b0001 << s.dir);
        else if (s.ack_dly >= 0 && k >= s.ack_dly) kill_ack = 4'b0001 << s.dir;
        else kill_ack = 4'd0;
        k++;
      end else kill_ack = 4'd0;
      if (q_Cool) n_cool++;
      tick();
    end
    kill_ack = 4'd0;
    check($sformatf("shot%0d_ready", idx), 64'(q_Ready), 64'd1);
    check($sformatf("shot%0d_req_cycles", idx), 64'(n_req), 64'(s.exp_req));
    check($sformatf("shot%0d_cool_cycles", idx), 64'(n_cool), 64'(COOL_N));
    check($sformatf("shot%0d_hits", idx), 64'(hits), 64'(h0 + s.exp_hit));
    check($sformatf("shot%0d_misses", idx), 64'(misses), 64'(m0 + 1 - s.exp_hit));
    check($sformatf("shot%0d_ammo", idx), 64'(ammo), 64'(AMMO_N - 1));
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, n;
    shots[0] = '{2'd0, 1'b1,  1, 1'b0, 2, 1};
    shots[1] = '{2'd3, 1'b1,  0, 1'b0, 1, 1};
    shots[2] = '{2'd1, 1'b1, -1, 1'b0, 5, 0};
    shots[3] = '{2'd2, 1'b0, -1, 1'b0, 0, 0};
    shots[4] = '{2'd1, 1'b1, -1, 1'b1, 5, 0};
    shots[5] = '{2'd2, 1'b1,  3, 1'b0, 4, 1};

    model_reset();
    repeat (2) @(negedge Clk);
    check("rst_idle", 64'(q_Idle), 64'd1);
    check("rst_ammo", 64'(ammo), 64'(AMMO_N));
    check("rst_outs", 64'({kill_req, repair_done, hits, misses, q_Ready, q_Fire, q_Cool, q_Repair, q_Done}), 64'd0);
    Reset = 1'b0;
    tick();
    check("idle_hold", 64'(q_Idle), 64'd1);

    for (int i = 0; i < 6; i++) run_shot(shots[i], i);

    // empty magazine: fourth fire is ignored
    refill();
    monster_present = 4'd0; dir_sel = 2'd1; m0 = m_miss;
    repeat (3) begin btn_fire = 1'b1; tick(); btn_fire = 1'b0; wait_ready(); end
    check("empty_ammo", 64'(ammo), 64'd0);
    check("empty_misses", 64'(misses), 64'(m0 + 3));
    btn_fire = 1'b1; tick(); btn_fire = 1'b0;
    check("empty_ready", 64'(q_Ready), 64'd1);
    check("empty_misses_hold", 64'(misses), 64'(m0 + 3));

    // completed repair reloads the magazine
    broken = 4'b0100; dir_sel = 2'd2;
    btn_repair = 1'b1; tick(); btn_repair = 1'b0;
    check("repair_entry", 64'(q_Repair), 64'd1);
    n = 0;
    while (repair_done == 4'd0 && n < 20) begin tick(); n++; end
    check("repair_latency", 64'(n), 64'(REP_N));
    check("repair_pulse", 64'(repair_done), 64'b0100);
    check("repair_ammo", 64'(ammo), 64'(AMMO_N));
    tick();
    check("repair_pulse_end", 64'(repair_done), 64'd0);
    check("repair_ready", 64'(q_Ready), 64'd1);

    // aborted repair: no pulse, no reload
    btn_fire = 1'b1; tick(); btn_fire = 1'b0; wait_ready();
    btn_repair = 1'b1; tick(); btn_repair = 1'b0;
    repeat (3) tick();
    broken = 4'd0; tick();
    check("abort_ready", 64'(q_Ready), 64'd1);
    check("abort_no_pulse", 64'(repair_done), 64'd0);
    check("abort_ammo", 64'(ammo), 64'(AMMO_N - 1));
    repeat (12) tick();
`ifdef NEXYS_STARSHIP_AUTO_RELOAD_EN
    check("reload_ammo", 64'(ammo), 64'(AMMO_N));
`else
    check("no_reload_ammo", 64'(ammo), 64'(AMMO_N - 1));
`endif

    // asynchronous reset in the middle of a handshake
    refill();
    monster_present = 4'b0001; dir_sel = 2'd0;
    btn_fire = 1'b1; tick(); btn_fire = 1'b0;
    check("hs_req", 64'(kill_req), 64'b0001);
    #2 Reset = 1'b1;
    #1 check("async_rst_req", 64'(kill_req), 64'd0);
    check("async_rst_idle", 64'(q_Idle), 64'd1);
    tick();
    Reset = 1'b0;

    // fire beats repair; game_over freezes everything
    play_flag = 1'b1; tick();
    monster_present = 4'b0100; broken = 4'b0100; dir_sel = 2'd2;
    btn_fire = 1'b1; btn_repair = 1'b1; tick(); btn_fire = 1'b0; btn_repair = 1'b0;
    check("prio_fire", 64'(q_Fire), 64'd1);
    check("prio_req", 64'(kill_req), 64'b0100);
    game_over = 1'b1; tick(); game_over = 1'b0;
    check("go_req", 64'(kill_req), 64'd0);
    check("go_done", 64'(q_Done), 64'd1);
    play_flag = 1'b0; btn_fire = 1'b1; btn_repair = 1'b1; kill_ack = 4'b1111;
    repeat (2) tick();
    btn_fire = 1'b0; btn_repair = 1'b0; kill_ack = 4'd0; play_flag = 1'b1;
    repeat (3) tick();
    check("done_hold", 64'(q_Done), 64'd1);
    check("done_outs", 64'({kill_req, repair_done}), 64'd0);
    do_reset();
    check("done_exit", 64'(q_Idle), 64'd1);

    // saturation of misses then hits
    play_flag = 1'b1; tick();
    monster_present = 4'd0; dir_sel = 2'd3;
    for (int i = 0; i < 260; i++) begin
      if (m_ammo == 0) refill();
      btn_fire = 1'b1; tick(); btn_fire = 1'b0; wait_ready();
    end
    check("misses_sat", 64'(misses), 64'd255);
    monster_present = 4'b1000; kill_ack = 4'b1000;
    for (int i = 0; i < 260; i++) begin
      if (m_ammo == 0) refill();
      btn_fire = 1'b1; tick(); btn_fire = 1'b0; wait_ready();
    end
    kill_ack = 4'd0;
    check("hits_sat", 64'(hits), 64'd255);
    check("misses_sat_hold", 64'(misses), 64'd255);

    // random stimulus against the model
    do_reset();
    broken = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      play_flag  = ($urandom_range(0, 39) != 0);
      game_over  = ($urandom_range(0, 299) == 0);
      btn_fire   = ($urandom_range(0, 4) == 0);
      btn_repair = ($urandom_range(0, 5) == 0);
      dir_sel    = 2'($urandom_range(0, 3));
      monster_present = 4'($urandom);
      if ($urandom_range(0, 15) == 0) broken = broken ^ (4'b0001 << $urandom_range(0, 3));
      for (int b = 0; b < 4; b++) kill_ack[b] = ($urandom_range(0, 3) == 0);
      tick();
      if (m_mode == M_DONE && $urandom_range(0, 9) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
